// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage and the multiply/divide sequencer.
// start is a request that is taken only while the sequencer is IDLE and flush is low; the request is consumed on that edge.
// done marks the single cycle in which Result is valid, and stall stays low in that cycle so the pipeline can capture Result.
interface muldiv_if #(parameter int DATA_W = 32);
  logic              start;
  logic [2:0]        Funct3;
  logic [DATA_W-1:0] SrcA;
  logic [DATA_W-1:0] SrcB;
  logic              flush;
  logic              busy;
  logic              stall;
  logic              done;
  logic [DATA_W-1:0] Result;
  logic              illegal;
  logic [1:0]        dbg_state;

  modport master (
    output start, Funct3, SrcA, SrcB, flush,
    input  busy, stall, done, Result, illegal, dbg_state
  );

  modport slave (
    input  start, Funct3, SrcA, SrcB, flush,
    output busy, stall, done, Result, illegal, dbg_state
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring shift-subtract steps on magnitudes, then sign fix-up.
// Define MULDIV_DIV_EN to build the divider; without it, DIV/DIVU/REM/REMU complete at once with illegal and Result 0.
module muldiv_sequencer #(
  parameter int DATA_W = 32
) (
  input logic     clk,
  input logic     reset,
  muldiv_if.slave bus
);
  localparam int W  = DATA_W;
  localparam int W2 = 2 * DATA_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [2:0]   op_q, op_d;
  logic         neg_q, neg_d;
  logic [W-1:0] hi_q, hi_d;
  logic [W-1:0] lo_q, lo_d;
  logic [W-1:0] opnd_q, opnd_d;
  logic [W-1:0] result_q, result_d;
  logic         illegal_q, illegal_d;
`ifdef MULDIV_DIV_EN
  logic         negr_q, negr_d;
  logic [W:0]   shifted, diff;
  logic [W-1:0] quot_fix, rem_fix;
`endif

  logic         accept, a_sgn, b_sgn, a_neg, b_neg;
  logic [W-1:0] a_mag, b_mag;
  logic [W:0]   sum;
  logic [W2-1:0] prod_fix;

  // Which operands are treated as signed for each op (MUL low word is sign-agnostic).
  always_comb begin
    a_sgn  = (bus.Funct3 == 3'b001) || (bus.Funct3 == 3'b010) ||
             (bus.Funct3 == 3'b100) || (bus.Funct3 == 3'b110);
    b_sgn  = (bus.Funct3 == 3'b001) || (bus.Funct3 == 3'b100) || (bus.Funct3 == 3'b110);
    a_neg  = a_sgn & bus.SrcA[W-1];
    b_neg  = b_sgn & bus.SrcB[W-1];
    a_mag  = a_neg ? -bus.SrcA : bus.SrcA;
    b_mag  = b_neg ? -bus.SrcB : bus.SrcB;
    accept = (state_q == IDLE) & bus.start & ~bus.flush;
  end

  // {hi,lo} is the 64-bit accumulator: product for multiply, {remainder, quotient} for divide.
  always_comb begin
    sum      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
`ifdef MULDIV_DIV_EN
    shifted  = {hi_q, lo_q[W-1]};
    diff     = shifted - {1'b0, opnd_q};
    quot_fix = neg_q ? -lo_q : lo_q;
    rem_fix  = negr_q ? -hi_q : hi_q;
`endif
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_d     = neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    result_d  = result_q;
    illegal_d = 1'b0;
`ifdef MULDIV_DIV_EN
    negr_d    = negr_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d  = bus.Funct3;
          neg_d = a_neg ^ b_neg;
          cnt_d = 5'd31;
          hi_d  = '0;
          if (bus.Funct3[2]) begin
`ifdef MULDIV_DIV_EN
            negr_d = a_neg;
            lo_d   = a_mag;
            opnd_d = b_mag;
            if (bus.SrcB == '0) begin
              result_d = bus.Funct3[1] ? bus.SrcA : '1;
              state_d  = DONE;
            end else begin
              state_d  = CALC;
            end
`else
            result_d  = '0;
            illegal_d = 1'b1;
            state_d   = DONE;
`endif
          end else begin
            lo_d    = b_mag;
            opnd_d  = a_mag;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd0) state_d = FIX;
`ifdef MULDIV_DIV_EN
          if (op_q[2]) begin
            if (!diff[W]) begin
              hi_d = diff[W-1:0];
              lo_d = {lo_q[W-2:0], 1'b1};
            end else begin
              hi_d = shifted[W-1:0];
              lo_d = {lo_q[W-2:0], 1'b0};
            end
          end else
`endif
          begin
            {hi_d, lo_d} = {sum, lo_q[W-1:1]};
          end
        end
      end
      FIX: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
`ifdef MULDIV_DIV_EN
          if (op_q[2]) result_d = op_q[1] ? rem_fix : quot_fix;
          else
`endif
          result_d = (op_q == 3'b000) ? prod_fix[W-1:0] : prod_fix[W2-1:W];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      negr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opnd_q    <= opnd_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
`ifdef MULDIV_DIV_EN
      negr_q    <= negr_d;
`endif
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.stall     = (bus.start & (state_q == IDLE)) | (state_q == CALC) | (state_q == FIX);
  assign bus.done      = (state_q == DONE);
  assign bus.Result    = result_q;
  assign bus.illegal   = illegal_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed plus randomized bench for muldiv_sequencer against an arithmetic reference model.
// Honours MULDIV_DIV_EN the same way as the design.
module tb_muldiv_sequencer;
  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  logic [31:0] last_exp;
  logic [31:0] exp_q[$];

  muldiv_if #(.DATA_W(32)) bus ();

  muldiv_sequencer #(.DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: RV32M results from plain 64-bit arithmetic; returns result, latency and illegal flag.
  task automatic model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output bit ill);
    longint      sa, sb, ub, p;
    logic [63:0] up;
    sa  = $signed(a);
    sb  = $signed(b);
    ub  = {32'b0, b};
    lat = 34;
    ill = 1'b0;
    res = '0;
    case (f3)
      3'd0: begin p = sa * sb; res = p[31:0]; end
      3'd1: begin p = sa * sb; res = p[63:32]; end
      3'd2: begin p = sa * ub; res = p[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; res = up[63:32]; end
      default: begin
`ifdef MULDIV_DIV_EN
        if (b == 32'd0) begin
          lat = 1;
          res = f3[1] ? a : 32'hFFFF_FFFF;
        end else begin
          case (f3)
            3'd4: begin p = sa / sb; res = p[31:0]; end
            3'd5: res = a / b;
            3'd6: begin p = sa % sb; res = p[31:0]; end
            default: res = a % b;
          endcase
        end
`else
        lat = 1;
        ill = 1'b1;
        res = '0;
`endif
      end
    endcase
  endtask

  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input bit poke);
    logic [31:0] exp, got_exp;
    int          lat_exp, lat;
    bit          ill_exp;
    model(f3, a, b, exp, lat_exp, ill_exp);
    exp_q.push_back(exp);
    @(negedge clk);
    bus.start = 1'b1; bus.Funct3 = f3; bus.SrcA = a; bus.SrcB = b;
    #1;
    check("stall_accept", bus.stall, 1);
    check("busy_accept", bus.busy, 0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.SrcA = $urandom; bus.SrcB = $urandom; bus.Funct3 = 3'($urandom_range(0, 7));
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
      check("stall_busy_cycle", {bus.stall, bus.busy}, 2'b11);
      if (poke && i == 5) bus.start = 1'b1;
      if (poke && i == 6) bus.start = 1'b0;
      @(posedge clk); #1;
    end
    check("latency", lat, lat_exp);
    got_exp = exp_q.pop_front();
    if (lat != 0) begin
      check("result", bus.Result, got_exp);
      check("illegal", bus.illegal, ill_exp);
      check("stall_done", bus.stall, 0);
    end
    @(posedge clk); #1;
    check("done_pulse", bus.done, 0);
    check("idle_after", bus.busy, 0);
    check("result_held", bus.Result, got_exp);
    last_exp = got_exp;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    last_exp = '0;
    reset = 1'b0;
    bus.start = 1'b0; bus.Funct3 = '0; bus.SrcA = '0; bus.SrcB = '0; bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_illegal", bus.illegal, 0);
    check("reset_result", bus.Result, 0);
    check("reset_stall", bus.stall, 0);
    reset = 1'b1;

    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);
    check("mul_7_neg3", last_exp, 32'hFFFF_FFEB);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    check("mulh_min", last_exp, 32'h4000_0000);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("mulhu_max", last_exp, 32'hFFFF_FFFE);
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    check("mulhsu_neg1", last_exp, 32'hFFFF_FFFF);
`ifdef MULDIV_DIV_EN
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_neg7_2", last_exp, 32'hFFFF_FFFD);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("rem_neg7_2", last_exp, 32'hFFFF_FFFF);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf", last_exp, 32'h8000_0000);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("rem_ovf", last_exp, 32'h0);
    do_op(3'd5, 32'd5, 32'd0, 1'b0);
    check("divu_by0", last_exp, 32'hFFFF_FFFF);
    do_op(3'd7, 32'd5, 32'd0, 1'b0);
    check("remu_by0", last_exp, 32'd5);
`else
    do_op(3'd4, 32'd5, 32'd1, 1'b0);
    check("div_disabled", last_exp, 32'h0);
`endif

    // Start pulsed during CALC must not disturb the running MUL.
    do_op(3'd0, 32'd1234, 32'd5678, 1'b1);
    check("mul_poked", last_exp, 32'd7006652);

    // Flush in CALC cycle 10, with a simultaneous start that must be dropped.
    do_op(3'd0, 32'd9, 32'd9, 1'b0);
    @(negedge clk);
    bus.start = 1'b1; bus.Funct3 = 3'd0; bus.SrcA = 32'd100; bus.SrcB = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("flush_pre_busy", bus.busy, 1);
    @(negedge clk);
    bus.flush = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.start = 1'b0;
    check("flush_busy", bus.busy, 0);
    check("flush_done", bus.done, 0);
    check("flush_result", bus.Result, last_exp);
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) break;
    end
    check("flush_no_late_done", {bus.done, bus.busy}, 2'b00);
    do_op(3'd0, 32'd6, 32'd7, 1'b0);
    check("after_flush", last_exp, 32'd42);

    // Reset in CALC cycle 20.
    @(negedge clk);
    bus.start = 1'b1; bus.Funct3 = 3'd3; bus.SrcA = 32'hDEAD_BEEF; bus.SrcB = 32'h1234_5678;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_result", bus.Result, 0);
    check("rst_illegal", bus.illegal, 0);
    reset = 1'b1;
    do_op(3'd0, 32'd3, 32'd4, 1'b0);
    check("after_reset", last_exp, 32'd12);

    for (int n = 0; n < 24; n++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 5) == 0) b = 32'hFFFF_FFFF;
      do_op(f3, a, b, (n % 5) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 SHALL have port start  input  1  issue request from EX stage, qualified by IDLE.
REQ-005 SHALL have port Funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have ports SrcA and SrcB  input  DATA_W each  operands (SrcA = multiplicand/dividend).
REQ-007 SHALL have port flush  input  1  abort request from the hazard unit.
REQ-008 SHALL have port busy  output  1  high in every non-IDLE state.
REQ-009 SHALL have port stall  output  1  combinational: (start & IDLE) | CALC | FIX.
REQ-010 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have port Result  output  DATA_W  registered result, held until the next done.
REQ-012 SHALL have port illegal  output  1  one-cycle pulse for a disabled op (see Configuration).

Function
REQ-013 SHALL implement states IDLE, CALC, FIX and DONE.
REQ-014 SHALL accept start only in IDLE with flush low, and latch Funct3, SrcA and SrcB on the accepting edge; later operand changes SHALL have no effect.
REQ-015 SHALL ignore start in any state other than IDLE.
REQ-016 SHALL, after acceptance, perform IDLE -> CALC for exactly 32 cycles, driven by a 5-bit counter running 31 down to 0.
REQ-017 SHALL, from CALC, pass through FIX (1 cycle) then DONE (1 cycle) -> IDLE; done SHALL be high in the 34th cycle after the accepting edge.
REQ-018 SHALL use radix-2 shift-add for multiplication on magnitudes and a 64-bit accumulator; MUL returns the low word; MULH, MULHSU and MULHU return the high word.
REQ-019 SHALL use restoring shift-subtract division on magnitudes.
REQ-020 SHALL apply sign correction in FIX by two's-complement negation of the 64-bit product or quotient/remainder, as RISC-V M requires (remainder takes the dividend's sign).
REQ-021 SHALL, on a divide by zero (divisor 0 at acceptance), go IDLE -> DONE directly with done one cycle after acceptance; DIV/DIVU SHALL return 0xFFFFFFFF and REM/REMU SHALL return SrcA.
REQ-022 SHALL, for signed overflow (0x80000000 / 0xFFFFFFFF), use the normal path: DIV returns 0x80000000, REM returns 0.
REQ-023 SHALL, when flush is high in any state, enter IDLE at the next edge with no done, Result unchanged, and any simultaneous start ignored.
REQ-024 SHALL keep stall low in DONE so the pipeline captures Result in that cycle.

Reset
REQ-025 SHALL, while reset is low at a rising edge, set state to IDLE, counter to 0, accumulators to 0, and busy=0, done=0, illegal=0, Result=0, regardless of the current state.
REQ-026 SHALL resume accepting start on the first edge after reset returns high.

Configuration
REQ-027 SHALL, with macro MULDIV_DIV_EN defined, implement all eight ops as above.
REQ-028 SHALL, without MULDIV_DIV_EN, omit the divider; Funct3 1xx SHALL go IDLE -> DONE with done and illegal pulsing together one cycle after acceptance and Result=0; multiply ops are unaffected.

Verification
REQ-029 SHALL cover: MUL SrcA=7, SrcB=0xFFFFFFFD -> Result 0xFFFFFFEB, done exactly 34 cycles after accept, stall high for cycles 0-33.
REQ-030 SHALL cover: MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-031 SHALL cover: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM of the same operands -> 0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 with REM -> 0.
REQ-032 SHALL cover: DIVU 5/0 -> 0xFFFFFFFF with done 1 cycle after accept; REMU 5/0 -> 5; with MULDIV_DIV_EN undefined, DIV 5/1 -> illegal=1, Result 0.
REQ-033 SHALL cover: flush at CALC cycle 10 -> IDLE next edge, no done, Result unchanged; a new start next cycle is accepted; start during CALC is ignored.
REQ-034 SHALL cover: reset low during CALC cycle 20 -> busy, done, Result all 0 at the next edge; a MUL 3x4 after release -> 12.
